// File: rtl/axis_elastic_buffer.sv
// N-entry AXI4-Stream elastic buffer: output register plus a (DEPTH-1)-entry ring, all outputs registered.
// Optional flush port enabled by defining AXIS_ELASTIC_BUFFER_FLUSH_EN.
module axis_elastic_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef AXIS_ELASTIC_BUFFER_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [ID_WIDTH-1:0]          s_axis_tid,
  input  logic [DEST_WIDTH-1:0]        s_axis_tdest,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [ID_WIDTH-1:0]          m_axis_tid,
  output logic [DEST_WIDTH-1:0]        m_axis_tdest,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic [$clog2(DEPTH+1)-1:0]   status_count,
  output logic                         status_full,
  output logic                         status_empty
);

  localparam int KW       = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 0;
  localparam int LW       = (LAST_ENABLE != 0) ? 1 : 0;
  localparam int IW       = (ID_ENABLE != 0) ? ID_WIDTH : 0;
  localparam int DW       = (DEST_ENABLE != 0) ? DEST_WIDTH : 0;
  localparam int UW       = (USER_ENABLE != 0) ? USER_WIDTH : 0;
  localparam int KEEP_OFF = DATA_WIDTH;
  localparam int LAST_OFF = KEEP_OFF + KW;
  localparam int ID_OFF   = LAST_OFF + LW;
  localparam int DEST_OFF = ID_OFF + IW;
  localparam int USER_OFF = DEST_OFF + DW;
  localparam int WORD_W   = USER_OFF + UW;
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int ADEPTH   = DEPTH - 1;
  localparam int AW       = (DEPTH > 2) ? $clog2(ADEPTH) : 1;

  logic [WORD_W-1:0] r_mem [0:ADEPTH-1];
  logic [WORD_W-1:0] r_out_word;
  logic              r_out_valid;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_s_tready;
  logic              r_full;
  logic              r_empty;

  wire  [WORD_W-1:0] w_s_word;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_arr_empty;
  logic              w_out_free;
  logic              w_bypass;
  logic              w_arr_wr;
  logic              w_refill;
  logic [CW-1:0]     w_count_next;
  logic [AW-1:0]     w_wptr_next;
  logic [AW-1:0]     w_rptr_next;
  logic              w_out_valid_next;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(ADEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  // Only enabled sideband fields occupy storage; disabled outputs are tied to constants.
  assign w_s_word[DATA_WIDTH-1:0] = s_axis_tdata;
  assign m_axis_tdata = r_out_word[DATA_WIDTH-1:0];

  if (KEEP_ENABLE != 0) begin : g_keep_on
    assign w_s_word[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
    assign m_axis_tkeep = r_out_word[KEEP_OFF +: KEEP_WIDTH];
  end else begin : g_keep_off
    assign m_axis_tkeep = {KEEP_WIDTH{1'b1}};
  end

  if (LAST_ENABLE != 0) begin : g_last_on
    assign w_s_word[LAST_OFF] = s_axis_tlast;
    assign m_axis_tlast = r_out_word[LAST_OFF];
  end else begin : g_last_off
    assign m_axis_tlast = 1'b1;
  end

  if (ID_ENABLE != 0) begin : g_id_on
    assign w_s_word[ID_OFF +: ID_WIDTH] = s_axis_tid;
    assign m_axis_tid = r_out_word[ID_OFF +: ID_WIDTH];
  end else begin : g_id_off
    assign m_axis_tid = {ID_WIDTH{1'b0}};
  end

  if (DEST_ENABLE != 0) begin : g_dest_on
    assign w_s_word[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
    assign m_axis_tdest = r_out_word[DEST_OFF +: DEST_WIDTH];
  end else begin : g_dest_off
    assign m_axis_tdest = {DEST_WIDTH{1'b0}};
  end

  if (USER_ENABLE != 0) begin : g_user_on
    assign w_s_word[USER_OFF +: USER_WIDTH] = s_axis_tuser;
    assign m_axis_tuser = r_out_word[USER_OFF +: USER_WIDTH];
  end else begin : g_user_off
    assign m_axis_tuser = {USER_WIDTH{1'b0}};
  end

  wire w_unused = ^{s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};

  // The ring holds exactly count minus the output-register word, so it is empty when they match.
  assign w_in_xfer   = s_axis_tvalid & r_s_tready;
  assign w_out_xfer  = r_out_valid & m_axis_tready;
  assign w_arr_empty = (r_count == {{(CW-1){1'b0}}, r_out_valid});
  assign w_out_free  = ~r_out_valid | w_out_xfer;
  assign w_bypass    = w_in_xfer & w_arr_empty & w_out_free;
  assign w_arr_wr    = w_in_xfer & ~w_bypass;
  assign w_refill    = w_out_free & ~w_arr_empty;

  // Next-state for occupancy, pointers and output valid.
  always_comb begin
    w_count_next     = r_count;
    w_wptr_next      = r_wptr;
    w_rptr_next      = r_rptr;
    w_out_valid_next = r_out_valid;
    w_count_next = r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
    if (w_arr_wr) begin
      w_wptr_next = ptr_inc(r_wptr);
    end else begin
      w_wptr_next = r_wptr;
    end
    if (w_refill) begin
      w_rptr_next = ptr_inc(r_rptr);
    end else begin
      w_rptr_next = r_rptr;
    end
    if (w_bypass || w_refill) begin
      w_out_valid_next = 1'b1;
    end else if (w_out_xfer) begin
      w_out_valid_next = 1'b0;
    end else begin
      w_out_valid_next = r_out_valid;
    end
  end

  // Control registers; tready is computed from next count so it never sees m_axis_tready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_wptr      <= {AW{1'b0}};
      r_rptr      <= {AW{1'b0}};
      r_s_tready  <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end
`ifdef AXIS_ELASTIC_BUFFER_FLUSH_EN
    else if (flush) begin
      r_count     <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_wptr      <= {AW{1'b0}};
      r_rptr      <= {AW{1'b0}};
      r_s_tready  <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end
`endif
    else begin
      r_count     <= w_count_next;
      r_out_valid <= w_out_valid_next;
      r_wptr      <= w_wptr_next;
      r_rptr      <= w_rptr_next;
      r_s_tready  <= (w_count_next < CW'(DEPTH));
      r_full      <= (w_count_next == CW'(DEPTH));
      r_empty     <= (w_count_next == {CW{1'b0}});
    end
  end

  // Datapath storage carries no reset: contents are qualified by the valid/count state.
  always_ff @(posedge clk) begin
    if (w_arr_wr) begin
      r_mem[r_wptr] <= w_s_word;
    end
    if (w_bypass) begin
      r_out_word <= w_s_word;
    end else if (w_refill) begin
      r_out_word <= r_mem[r_rptr];
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_out_valid;
  assign status_count  = r_count;
  assign status_full   = r_full;
  assign status_empty  = r_empty;

endmodule
